fb_wr_sched: RTL and testbench
==============================

Name: fb_wr_sched

Overview:
- Write-side scheduler for the 640x480, 8-bit-index VGA frame buffer.
- Shares the buffer's single write port (wraddress/data/wren, on the user write clock) between two requesters:
  - a host pixel port, using a req/ack handshake;
  - an internal rectangle-fill engine, which walks a rectangle and writes one colour index per pixel.
- Arbitration is round-robin on contention. All write-port outputs are registered.

Parameters:
- H_RES, 640, pixels per line; also the address stride per row.
- V_RES, 480, lines per frame.
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 8, colour-index width.

Ports:
- iclk  in  1  write-side clock; the only clock.
- iRST  in  1  asynchronous, active-high reset.
- ihost_req  in  1  host write request.
- ihost_addr  in  ADDR_W  host write address.
- ihost_data  in  DATA_W  host write data.
- ohost_ack  out  1  combinational; host beat consumed this cycle.
- ifill_start  in  1  single-cycle fill command strobe.
- ifill_x  in  10  rectangle left column.
- ifill_y  in  9  rectangle top row.
- ifill_w  in  10  rectangle width in pixels.
- ifill_h  in  9  rectangle height in lines.
- ifill_color  in  DATA_W  fill colour index.
- ofill_busy  out  1  fill in progress.
- ofill_done  out  1  one-cycle completion pulse.
- owren  out  1  frame-buffer write enable.
- oaddr  out  ADDR_W  frame-buffer write address.
- odata  out  DATA_W  frame-buffer write data.

Behaviour:
- Reset values: owren=0, oaddr=0, odata=0, ofill_busy=0, ofill_done=0; fill FSM in IDLE; round-robin pointer points at host.
- Reset asserted mid-operation aborts the fill and drops any pending write.
- Fill FSM states:
  - IDLE: on ifill_start, latch all command fields and go to SETUP. ifill_start while not in IDLE is ignored.
  - SETUP (1 cycle): if w==0 or h==0, go to DONE with no writes. Otherwise rowbase = y*H_RES + x (full ADDR_W width), col=0, row=0, go to RUN.
  - RUN: fill requests every cycle. On each grant: col++. When col==w-1: col=0, row++, rowbase += H_RES. When the grant falls on the last pixel (row==h-1, col==w-1), go to DONE.
  - DONE (1 cycle): ofill_done=1, then go to IDLE.
- ofill_busy is high in SETUP, RUN and DONE.
- Arbitration (evaluated each cycle):
  - Only one requester active: it wins.
  - Both active: the requester not granted last time wins, and the pointer toggles on every contended grant.
  - Host request with no contention is acked immediately, so the host writes at 1 beat/cycle while idle.
- Host handshake: ohost_ack = ihost_req & host_grant. The host may hold ihost_req high with new addr/data each cycle; each ack consumes exactly one beat. Host address is passed through unchecked.
- Latency: grant in cycle N gives owren=1, oaddr, odata in cycle N+1. With no grant in cycle N, owren=0 in N+1 and oaddr/odata hold their values.
- Throughput: fill alone runs at 1 pixel/cycle; under continuous contention each requester gets 1 write per 2 cycles.
- Write ordering: writes appear on the port in grant order. There is no hazard tracking between host and fill writes to the same address; the later write wins.

Optional Feature:
- Macro: FB_FILL_CLIP_EN.
- Defined: pixels with x+col >= H_RES or y+row >= V_RES are walked but not written (grant is consumed, owren stays 0), so the rectangle is clipped at the screen edge.
- Undefined: in SETUP, a command with x+w > H_RES or y+h > V_RES is rejected. The FSM goes straight to DONE, ofill_done pulses, and no writes are issued.

Decomposition:
- Package vga_fb_pkg:
  - constants H_RES, V_RES, ADDR_W, DATA_W, X_W=10, Y_W=9;
  - fill state enum {IDLE, SETUP, RUN, DONE}.
- Sub-module fb_rect_walker: fill FSM, col/row counters and rowbase address generation. It exposes req/addr/data/grant/busy/done.
- Top level fb_wr_sched holds the round-robin arbiter and the output registers.

Test Plan:
- Host only: req with addr=0x00010, data=0x5A for 1 cycle -> ack same cycle; next cycle owren=1, oaddr=0x00010, odata=0x5A.
- Fill x=2, y=1, w=3, h=2, color=0x11, no host traffic -> owren on 6 consecutive cycles, addresses 642,643,644,1282,1283,1284; ofill_done pulses once, in the cycle after the last grant, aligned with the last owren.
- Contention: fill w=4, h=1 while host req is held high for 8 beats -> grants alternate host/fill; fill completes in 8 cycles; every host beat is acked exactly once, in order.
- Zero-size fill, w=0 -> no owren, ofill_done 2 cycles after ifill_start; ifill_start during busy is ignored (no extra done pulse).
- Edge fill x=638, y=479, w=4, h=1:
  - FB_FILL_CLIP_EN defined -> writes only to addresses 307198 and 307199;
  - undefined -> no writes, done pulse.
- iRST asserted mid-RUN -> all outputs 0 immediately; after release, a new fill runs correctly and the RR pointer is back at host.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants and fill-state encoding for the VGA frame-buffer write path.
// Geometry is fixed at 640x480 with 8-bit colour indices.
package vga_fb_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle-fill engine: latches a fill command and offers one pixel write per cycle, row by row.
// FB_FILL_CLIP_EN: clip off-screen pixels instead of rejecting rectangles that cross the screen edge.
module fb_rect_walker
    import vga_fb_pkg::*;
(
    input  logic              iclk,
    input  logic              iRST,
    input  logic              start,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    input  logic [DATA_W-1:0] color,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              wr_ok,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);
    localparam logic [X_W:0]      H_LIM  = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      V_LIM  = (Y_W+1)'(V_RES);

    fill_state_t       state, state_nxt;
    logic [X_W-1:0]    x_q, w_q, col;
    logic [Y_W-1:0]    y_q, h_q, row;
    logic [DATA_W-1:0] color_q;
    logic [ADDR_W-1:0] rowbase;
    logic              last_col, last_row, empty, reject;

    assign last_col = (col == (w_q - X_W'(1)));
    assign last_row = (row == (h_q - Y_W'(1)));
    assign empty    = (w_q == '0) || (h_q == '0);

`ifdef FB_FILL_CLIP_EN
    logic [X_W:0] cur_x;
    logic [Y_W:0] cur_y;

    // Off-screen pixels still take their grant so the walk timing is independent of clipping.
    assign cur_x  = {1'b0, x_q} + {1'b0, col};
    assign cur_y  = {1'b0, y_q} + {1'b0, row};
    assign wr_ok  = (cur_x < H_LIM) && (cur_y < V_LIM);
    assign reject = 1'b0;
`else
    logic [X_W:0] end_x;
    logic [Y_W:0] end_y;

    assign end_x  = {1'b0, x_q} + {1'b0, w_q};
    assign end_y  = {1'b0, y_q} + {1'b0, h_q};
    assign reject = (end_x > H_LIM) || (end_y > V_LIM);
    assign wr_ok  = 1'b1;
`endif

    assign req  = (state == RUN);
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign addr = rowbase + ADDR_W'(col);
    assign data = color_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = (empty || reject) ? DONE : RUN;
            RUN:     if (grant && last_col && last_row) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command fields and walk counters are only meaningful outside IDLE, so they carry no reset.
    always_ff @(posedge iclk) begin
        if (state == IDLE && start) begin
            x_q     <= x;
            y_q     <= y;
            w_q     <= w;
            h_q     <= h;
            color_q <= color;
        end
        if (state == SETUP) begin
            rowbase <= ADDR_W'(y_q) * STRIDE + ADDR_W'(x_q);
            col     <= '0;
            row     <= '0;
        end else if (state == RUN && grant) begin
            if (last_col) begin
                col     <= '0;
                row     <= row + Y_W'(1);
                rowbase <= rowbase + STRIDE;
            end else begin
                col <= col + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_wr_sched.sv
// Frame-buffer write-port scheduler: round-robin between the host pixel port and the fill engine.
// FB_FILL_CLIP_EN selects clipping (defined) or rejection (undefined) of off-screen fills.
module fb_wr_sched
    import vga_fb_pkg::*;
(
    input  logic              iclk,
    input  logic              iRST,
    input  logic              ihost_req,
    input  logic [ADDR_W-1:0] ihost_addr,
    input  logic [DATA_W-1:0] ihost_data,
    output logic              ohost_ack,
    input  logic              ifill_start,
    input  logic [X_W-1:0]    ifill_x,
    input  logic [Y_W-1:0]    ifill_y,
    input  logic [X_W-1:0]    ifill_w,
    input  logic [Y_W-1:0]    ifill_h,
    input  logic [DATA_W-1:0] ifill_color,
    output logic              ofill_busy,
    output logic              ofill_done,
    output logic              owren,
    output logic [ADDR_W-1:0] oaddr,
    output logic [DATA_W-1:0] odata
);

    logic              fill_req, fill_wr_ok;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              contend_p0, host_grant_p0, fill_grant_p0, fill_wr_p0;
    logic              rr_host_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    fb_rect_walker u_walker (
        .iclk  (iclk),
        .iRST  (iRST),
        .start (ifill_start),
        .x     (ifill_x),
        .y     (ifill_y),
        .w     (ifill_w),
        .h     (ifill_h),
        .color (ifill_color),
        .grant (fill_grant_p0),
        .req   (fill_req),
        .addr  (fill_addr),
        .data  (fill_data),
        .wr_ok (fill_wr_ok),
        .busy  (ofill_busy),
        .done  (ofill_done)
    );

    // Stage p0: arbitration
    assign contend_p0 = ihost_req && fill_req;

    always_comb begin
        host_grant_p0 = ihost_req;
        fill_grant_p0 = fill_req;
        if (contend_p0) begin
            host_grant_p0 = rr_host_p0;
            fill_grant_p0 = !rr_host_p0;
        end
    end

    assign fill_wr_p0 = fill_grant_p0 && fill_wr_ok;
    assign ohost_ack  = ihost_req && host_grant_p0;

    // Pointer only moves on contention, so an idle-period host stream never biases the next tie.
    always_ff @(posedge iclk or posedge iRST) begin
        if (iRST) begin
            rr_host_p0 <= 1'b1;
        end else if (contend_p0) begin
            rr_host_p0 <= !rr_host_p0;
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge iclk or posedge iRST) begin
        if (iRST) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= host_grant_p0 || fill_wr_p0;
            if (host_grant_p0) begin
                addr_p1 <= ihost_addr;
                data_p1 <= ihost_data;
            end else if (fill_wr_p0) begin
                addr_p1 <= fill_addr;
                data_p1 <= fill_data;
            end
        end
    end

    assign owren = vld_p1;
    assign oaddr = addr_p1;
    assign odata = data_p1;

endmodule

// File: tb/tb_fb_wr_sched.sv
// Directed bench for fb_wr_sched: host vector table plus fill, contention, edge and reset sequences.
// Edge-fill expectations follow FB_FILL_CLIP_EN when the bench is built with it.
module tb_fb_wr_sched;
    import vga_fb_pkg::*;

    logic              iclk = 1'b0;
    logic              iRST;
    logic              ihost_req;
    logic [ADDR_W-1:0] ihost_addr;
    logic [DATA_W-1:0] ihost_data;
    logic              ohost_ack;
    logic              ifill_start;
    logic [X_W-1:0]    ifill_x;
    logic [Y_W-1:0]    ifill_y;
    logic [X_W-1:0]    ifill_w;
    logic [Y_W-1:0]    ifill_h;
    logic [DATA_W-1:0] ifill_color;
    logic              ofill_busy, ofill_done, owren;
    logic [ADDR_W-1:0] oaddr;
    logic [DATA_W-1:0] odata;

    int checks = 0;
    int errors = 0;

    always #5 iclk = ~iclk;

    fb_wr_sched dut (
        .iclk        (iclk),
        .iRST        (iRST),
        .ihost_req   (ihost_req),
        .ihost_addr  (ihost_addr),
        .ihost_data  (ihost_data),
        .ohost_ack   (ohost_ack),
        .ifill_start (ifill_start),
        .ifill_x     (ifill_x),
        .ifill_y     (ifill_y),
        .ifill_w     (ifill_w),
        .ifill_h     (ifill_h),
        .ifill_color (ifill_color),
        .ofill_busy  (ofill_busy),
        .ofill_done  (ofill_done),
        .owren       (owren),
        .oaddr       (oaddr),
        .odata       (odata)
    );

    typedef struct {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              exp_ack;
        logic              exp_wren;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
    } host_vec_t;

    host_vec_t tbl [6];

    logic              log_wren [32];
    logic [ADDR_W-1:0] log_addr [32];
    logic [DATA_W-1:0] log_data [32];
    logic              log_ack  [32];
    logic              log_busy [32];
    logic              log_done [32];
    int                beats_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs ncyc cycles from a negedge; host beats use addr 0x100+n / data 0xA0+n.
    task automatic run_seq(input logic [X_W-1:0] fx, input logic [Y_W-1:0] fy,
                           input logic [X_W-1:0] fw, input logic [Y_W-1:0] fh,
                           input logic [DATA_W-1:0] fc, input logic [31:0] start_mask,
                           input int host_start, input int host_beats, input int ncyc);
        int hb;
        hb = 0;
        for (int k = 0; k < ncyc; k++) begin
            ifill_start = start_mask[k];
            ifill_x     = fx;
            ifill_y     = fy;
            ifill_w     = fw;
            ifill_h     = fh;
            ifill_color = fc;
            ihost_req   = (k >= host_start) && (hb < host_beats);
            ihost_addr  = ADDR_W'(32'h100 + hb);
            ihost_data  = DATA_W'(32'hA0 + hb);
            #1;
            log_wren[k] = owren;
            log_addr[k] = oaddr;
            log_data[k] = odata;
            log_ack[k]  = ohost_ack;
            log_busy[k] = ofill_busy;
            log_done[k] = ofill_done;
            if (ohost_ack) hb++;
            @(negedge iclk);
        end
        ifill_start = 1'b0;
        ihost_req   = 1'b0;
        beats_done  = hb;
    endtask

    initial begin
        int exp_a [16];
        int exp_ack_c [16];

        tbl[0] = '{1'b1, 19'h00010, 8'h5A, 1'b1, 1'b0, 19'h00000, 8'h00};
        tbl[1] = '{1'b0, 19'h00000, 8'h00, 1'b0, 1'b1, 19'h00010, 8'h5A};
        tbl[2] = '{1'b1, 19'h7FFFF, 8'hFF, 1'b1, 1'b0, 19'h00010, 8'h5A};
        tbl[3] = '{1'b1, 19'h12345, 8'h3C, 1'b1, 1'b1, 19'h7FFFF, 8'hFF};
        tbl[4] = '{1'b0, 19'h00000, 8'h00, 1'b0, 1'b1, 19'h12345, 8'h3C};
        tbl[5] = '{1'b0, 19'h00000, 8'h00, 1'b0, 1'b0, 19'h12345, 8'h3C};

        iRST = 1'b1;
        ihost_req = 1'b0; ihost_addr = '0; ihost_data = '0;
        ifill_start = 1'b0; ifill_x = '0; ifill_y = '0; ifill_w = '0; ifill_h = '0; ifill_color = '0;
        repeat (2) @(negedge iclk);
        iRST = 1'b0;

        // Host-only vectors, starting from reset state
        chk("reset_busy", 32'(ofill_busy), 0);
        chk("reset_done", 32'(ofill_done), 0);
        for (int i = 0; i < 6; i++) begin
            ihost_req  = tbl[i].req;
            ihost_addr = tbl[i].addr;
            ihost_data = tbl[i].data;
            #1;
            chk($sformatf("host_ack[%0d]", i),  32'(ohost_ack), 32'(tbl[i].exp_ack));
            chk($sformatf("host_wren[%0d]", i), 32'(owren),     32'(tbl[i].exp_wren));
            chk($sformatf("host_addr[%0d]", i), 32'(oaddr),     32'(tbl[i].exp_addr));
            chk($sformatf("host_data[%0d]", i), 32'(odata),     32'(tbl[i].exp_data));
            @(negedge iclk);
        end
        ihost_req = 1'b0;

        // Fill 3x2 at (2,1): writes in cycles 3..8, done in 8
        run_seq(10'd2, 9'd1, 10'd3, 9'd2, 8'h11, 32'h1, 99, 0, 12);
        exp_a = '{-1, -1, -1, 642, 643, 644, 1282, 1283, 1284, -1, -1, -1, -1, -1, -1, -1};
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("fill_wren[%0d]", k), 32'(log_wren[k]), 32'(exp_a[k] >= 0));
            if (exp_a[k] >= 0) begin
                chk($sformatf("fill_addr[%0d]", k), 32'(log_addr[k]), 32'(exp_a[k]));
                chk($sformatf("fill_data[%0d]", k), 32'(log_data[k]), 32'h11);
            end
            chk($sformatf("fill_done[%0d]", k), 32'(log_done[k]), 32'(k == 8));
            chk($sformatf("fill_busy[%0d]", k), 32'(log_busy[k]), 32'(k >= 1 && k <= 8));
        end

        // Contention: fill 4x1 at origin, host holds req for 8 beats from the first RUN cycle
        run_seq(10'd0, 9'd0, 10'd4, 9'd1, 8'h22, 32'h1, 2, 8, 16);
        exp_a     = '{-1, -1, -1, 'h100, 0, 'h101, 1, 'h102, 2, 'h103, 3, 'h104, 'h105, 'h106, 'h107, -1};
        exp_ack_c = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0};
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rr_ack[%0d]", k),  32'(log_ack[k]),  32'(exp_ack_c[k]));
            chk($sformatf("rr_wren[%0d]", k), 32'(log_wren[k]), 32'(exp_a[k] >= 0));
            if (exp_a[k] >= 0) begin
                chk($sformatf("rr_addr[%0d]", k), 32'(log_addr[k]), 32'(exp_a[k]));
                chk($sformatf("rr_data[%0d]", k), 32'(log_data[k]),
                    (exp_a[k] >= 'h100) ? 32'(32'hA0 + exp_a[k] - 'h100) : 32'h22);
            end
            chk($sformatf("rr_done[%0d]", k), 32'(log_done[k]), 32'(k == 10));
        end
        chk("rr_beats", 32'(beats_done), 8);

        // Zero width, with extra starts while busy
        run_seq(10'd5, 9'd5, 10'd0, 9'd3, 8'h33, 32'h7, 99, 0, 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("zero_wren[%0d]", k), 32'(log_wren[k]), 0);
            chk($sformatf("zero_done[%0d]", k), 32'(log_done[k]), 32'(k == 2));
        end

        // Rectangle crossing the right edge of the last line
        run_seq(10'd638, 9'd479, 10'd4, 9'd1, 8'h44, 32'h1, 99, 0, 10);
`ifdef FB_FILL_CLIP_EN
        exp_a = '{-1, -1, -1, 307198, 307199, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("edge_wren[%0d]", k), 32'(log_wren[k]), 32'(exp_a[k] >= 0));
            if (exp_a[k] >= 0) chk($sformatf("edge_addr[%0d]", k), 32'(log_addr[k]), 32'(exp_a[k]));
            chk($sformatf("edge_done[%0d]", k), 32'(log_done[k]), 32'(k == 6));
        end
`else
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("edge_wren[%0d]", k), 32'(log_wren[k]), 0);
            chk($sformatf("edge_done[%0d]", k), 32'(log_done[k]), 32'(k == 2));
        end
`endif

        // Rectangle ending exactly on the bottom-right pixel is accepted in both builds
        run_seq(10'd637, 9'd479, 10'd3, 9'd1, 8'h55, 32'h1, 99, 0, 8);
        exp_a = '{-1, -1, -1, 307197, 307198, 307199, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fit_wren[%0d]", k), 32'(log_wren[k]), 32'(exp_a[k] >= 0));
            if (exp_a[k] >= 0) chk($sformatf("fit_addr[%0d]", k), 32'(log_addr[k]), 32'(exp_a[k]));
            chk($sformatf("fit_done[%0d]", k), 32'(log_done[k]), 32'(k == 5));
        end

        // Reset mid-RUN after one contended host grant has moved the pointer to fill
        run_seq(10'd0, 9'd0, 10'd4, 9'd1, 8'h66, 32'h1, 2, 1, 3);
        chk("pre_rst_ack", 32'(log_ack[2]), 1);
        #1;
        chk("pre_rst_wren", 32'(owren), 1);
        chk("pre_rst_busy", 32'(ofill_busy), 1);
        iRST = 1'b1;
        #1;
        chk("rst_wren", 32'(owren), 0);
        chk("rst_addr", 32'(oaddr), 0);
        chk("rst_data", 32'(odata), 0);
        chk("rst_busy", 32'(ofill_busy), 0);
        chk("rst_done", 32'(ofill_done), 0);
        @(negedge iclk);
        iRST = 1'b0;

        run_seq(10'd1, 9'd0, 10'd2, 9'd1, 8'h77, 32'h1, 2, 1, 8);
        exp_a = '{-1, -1, -1, 'h100, 1, 2, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        chk("post_rst_ack", 32'(log_ack[2]), 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("post_wren[%0d]", k), 32'(log_wren[k]), 32'(exp_a[k] >= 0));
            if (exp_a[k] >= 0) chk($sformatf("post_addr[%0d]", k), 32'(log_addr[k]), 32'(exp_a[k]));
            chk($sformatf("post_done[%0d]", k), 32'(log_done[k]), 32'(k == 5));
        end
        chk("post_data_fill", 32'(log_data[4]), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
